pipeline_flow_ctrl: RTL and testbench
=====================================

Name: pipeline_flow_ctrl

Overview:
Central control-flow sequencer for the rv32imc pipeline. It arbitrates the competing PC-update sources (trap, mret, branch/jump redirect, sequential) and drives the PC register's writeEn and pcSelect. It generates IF/ID/EX stalls and flushes. It holds a redirect pending while an instruction fetch is outstanding, so a stale fetch response is discarded instead of corrupting the PC.

Parameters:
XLEN, 32, datapath/PC width
TRAP_VECTOR, 32'h0000_0100, fixed trap handler address

Ports:
clk  in  1  clock
arstn  in  1  reset, asynchronous, active-low
redirectValid  in  1  EX: taken branch / jal / jalr this cycle
redirectTarget  in  XLEN  EX: redirect address (bit 0 already cleared)
trapReq  in  1  exception/ecall/ebreak raised this cycle
mretReq  in  1  mret in EX this cycle
mepc  in  XLEN  CSR mepc value
loadUse  in  1  ID reads rd of a load currently in EX
mduBusy  in  1  multi-cycle mul/div occupying EX
ifBusy  in  1  a fetch request is outstanding (PC must not change)
ifRespValid  in  1  fetch response returned this cycle
pcWriteEn  out  1  PC register write enable
pcSelect  out  2  0 = sequential, 1 = target, 2 = trap vector, 3 = mepc
targetPc  out  XLEN  address used when pcSelect is 1, 2 or 3
stallIf  out  1  hold IF/ID register
stallId  out  1  hold ID stage
stallEx  out  1  hold EX stage
flushIfId  out  1  bubble IF/ID
flushIdEx  out  1  bubble ID/EX
flushExMem  out  1  bubble EX/MEM (trap only)
mduKill  out  1  abort in-flight mul/div
ifDiscard  out  1  drop the fetch response returned this cycle

Behaviour:
- FSM states: RUN, HOLD.
- Registered state: pendSel[1:0], pendPc[XLEN-1:0].
- Reset (arstn low):
  - state is RUN; pendSel and pendPc are 0.
  - All outputs are forced to 0 regardless of inputs.
- Event priority, highest first: trapReq > mretReq > redirectValid > mduBusy > loadUse > sequential.
- Redirect class = trap, mret or redirect. Its selection:
  - trap: pcSelect 2, targetPc = TRAP_VECTOR.
  - mret: pcSelect 3, targetPc = mepc.
  - redirect: pcSelect 1, targetPc = redirectTarget.
- RUN, redirect-class event, ifBusy = 0:
  - pcWriteEn = 1 with the selection above, combinationally in the same cycle. PC takes the new value at the next edge (latency 1).
  - flushIfId = 1, flushIdEx = 1.
  - trap additionally asserts flushExMem = 1 and mduKill = 1.
- RUN, redirect-class event, ifBusy = 1:
  - pcWriteEn = 0.
  - Same flushes as the ifBusy = 0 case.
  - pendSel/pendPc latch the selection and address; go to HOLD.
- HOLD:
  - pcWriteEn = 0, flushIfId = 1 every cycle.
  - pcSelect = pendSel, targetPc = pendPc.
  - A trapReq arriving in HOLD overwrites pendSel = 2 and pendPc = TRAP_VECTOR, and asserts flushExMem and mduKill.
  - redirectValid and mretReq are ignored in HOLD; EX holds bubbles.
- HOLD exit on ifRespValid = 1:
  - ifDiscard = 1 and pcWriteEn = 1 with the pending selection, in the same cycle; go to RUN.
  - A trap in the same cycle takes precedence as the written value.
- mduBusy without a redirect-class event:
  - stallIf = stallId = stallEx = 1, pcWriteEn = 0, no flush.
  - redirectValid together with mduBusy is illegal; the bench asserts on it.
- loadUse alone:
  - stallIf = stallId = 1, pcWriteEn = 0, flushIdEx = 1 (one bubble). Duration equals the loadUse assertion.
  - A redirect in the same cycle wins: loadUse is ignored because the ID instruction is flushed.
- Sequential (no event, RUN):
  - pcWriteEn = !ifBusy, pcSelect = 0, all stalls and flushes 0.
  - The +2/+4 increment is chosen by the PC path, not here.
- Reset mid-HOLD: the pending redirect is lost and the state returns to RUN. The PC restarts from its own reset value.
- ifDiscard is asserted only in HOLD, and only for exactly one cycle.

Test Plan:
1. Branch, fetch idle: redirectValid = 1, redirectTarget = 0x0000_0040, ifBusy = 0 -> same cycle pcWriteEn = 1, pcSelect = 1, targetPc = 0x40, flushIfId = flushIdEx = 1; next cycle all outputs return to the sequential case.
2. Branch during fetch: redirectValid with ifBusy = 1; ifRespValid arrives 3 cycles later -> HOLD for 3 cycles with pcWriteEn = 0 and flushIfId = 1; in the response cycle ifDiscard = 1, pcWriteEn = 1, targetPc = redirectTarget; state returns to RUN.
3. Priority: trapReq, mretReq and redirectValid all asserted together -> pcSelect = 2, targetPc = 0x100, flushExMem = 1, mduKill = 1.
4. Trap overrides pending redirect: enter HOLD with a redirect to 0x80, then trapReq the next cycle -> at ifRespValid, pcSelect = 2, targetPc = 0x100, ifDiscard = 1.
5. Stalls: loadUse for 1 cycle -> stallIf = stallId = 1, flushIdEx = 1, pcWriteEn = 0; mduBusy for 33 cycles -> stallIf/stallId/stallEx held 33 cycles with no flush, then pcWriteEn = 1.
6. Reset: assert arstn low while in HOLD -> all outputs 0 immediately (asynchronously); after release, sequential pcWriteEn = 1 with no stray ifDiscard.

Source files
------------

// File: rtl/pipeline_flow_ctrl.sv
// Control-flow sequencer: arbitrates PC-update sources, generates stalls/flushes,
// and parks a redirect while a fetch is outstanding so the stale response is dropped.
module pipeline_flow_ctrl #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] TRAP_VECTOR = 'h0000_0100
) (
    input  logic            clk,
    input  logic            arstn,
    input  logic            redirectValid,
    input  logic [XLEN-1:0] redirectTarget,
    input  logic            trapReq,
    input  logic            mretReq,
    input  logic [XLEN-1:0] mepc,
    input  logic            loadUse,
    input  logic            mduBusy,
    input  logic            ifBusy,
    input  logic            ifRespValid,
    output logic            pcWriteEn,
    output logic [1:0]      pcSelect,
    output logic [XLEN-1:0] targetPc,
    output logic            stallIf,
    output logic            stallId,
    output logic            stallEx,
    output logic            flushIfId,
    output logic            flushIdEx,
    output logic            flushExMem,
    output logic            mduKill,
    output logic            ifDiscard
);

    typedef enum logic {RUN, HOLD} state_e;

    localparam logic [1:0] SEL_SEQ  = 2'd0;
    localparam logic [1:0] SEL_TGT  = 2'd1;
    localparam logic [1:0] SEL_TRAP = 2'd2;
    localparam logic [1:0] SEL_MEPC = 2'd3;

    state_e          state_q, state_d;
    logic [1:0]      pendSel_q, pendSel_d;
    logic [XLEN-1:0] pendPc_q, pendPc_d;

    // Winning redirect-class request in RUN (trap > mret > branch/jump)
    logic            redirCls;
    logic [1:0]      reqSel;
    logic [XLEN-1:0] reqPc;

    // Effective pending selection in HOLD: a fresh trap replaces the parked one
    logic [1:0]      holdSel;
    logic [XLEN-1:0] holdPc;

    assign redirCls = trapReq | mretReq | redirectValid;
    assign holdSel  = trapReq ? SEL_TRAP : pendSel_q;
    assign holdPc   = trapReq ? TRAP_VECTOR : pendPc_q;

    always_comb begin
        reqSel = SEL_TGT;
        reqPc  = redirectTarget;
        if (trapReq) begin
            reqSel = SEL_TRAP;
            reqPc  = TRAP_VECTOR;
        end else if (mretReq) begin
            reqSel = SEL_MEPC;
            reqPc  = mepc;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q   <= RUN;
            pendSel_q <= '0;
            pendPc_q  <= '0;
        end else begin
            state_q   <= state_d;
            pendSel_q <= pendSel_d;
            pendPc_q  <= pendPc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pendSel_d = pendSel_q;
        pendPc_d  = pendPc_q;
        if (state_q == RUN) begin
            if (redirCls && ifBusy) begin
                state_d   = HOLD;
                pendSel_d = reqSel;
                pendPc_d  = reqPc;
            end
        end else begin
            pendSel_d = holdSel;
            pendPc_d  = holdPc;
            if (ifRespValid) state_d = RUN;
        end
    end

    always_comb begin
        pcWriteEn  = 1'b0;
        pcSelect   = SEL_SEQ;
        targetPc   = '0;
        stallIf    = 1'b0;
        stallId    = 1'b0;
        stallEx    = 1'b0;
        flushIfId  = 1'b0;
        flushIdEx  = 1'b0;
        flushExMem = 1'b0;
        mduKill    = 1'b0;
        ifDiscard  = 1'b0;
        if (!arstn) begin
            // all outputs stay low while reset is asserted
        end else if (state_q == HOLD) begin
            pcSelect   = holdSel;
            targetPc   = holdPc;
            flushIfId  = 1'b1;
            flushExMem = trapReq;
            mduKill    = trapReq;
            pcWriteEn  = ifRespValid;
            ifDiscard  = ifRespValid;
        end else if (redirCls) begin
            pcSelect   = reqSel;
            targetPc   = reqPc;
            pcWriteEn  = !ifBusy;
            flushIfId  = 1'b1;
            flushIdEx  = 1'b1;
            flushExMem = trapReq;
            mduKill    = trapReq;
        end else if (mduBusy) begin
            stallIf = 1'b1;
            stallId = 1'b1;
            stallEx = 1'b1;
        end else if (loadUse) begin
            stallIf   = 1'b1;
            stallId   = 1'b1;
            flushIdEx = 1'b1;
        end else begin
            pcWriteEn = !ifBusy;
        end
    end

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Bench for pipeline_flow_ctrl: directed scenarios plus randomized traffic against
// a transaction-level model of the redirect/hold/stall rules.
module tb_pipeline_flow_ctrl;
    localparam int          XLEN = 32;
    localparam logic [31:0] TV   = 32'h0000_0100;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    logic redirectValid, trapReq, mretReq, loadUse, mduBusy, ifBusy, ifRespValid;
    logic [XLEN-1:0] redirectTarget, mepc;
    logic pcWriteEn, stallIf, stallId, stallEx, flushIfId, flushIdEx, flushExMem, mduKill, ifDiscard;
    logic [1:0] pcSelect;
    logic [XLEN-1:0] targetPc;

    always #5 clk = ~clk;

    pipeline_flow_ctrl #(.XLEN(XLEN), .TRAP_VECTOR(TV)) dut (
        .clk(clk), .arstn(arstn),
        .redirectValid(redirectValid), .redirectTarget(redirectTarget),
        .trapReq(trapReq), .mretReq(mretReq), .mepc(mepc),
        .loadUse(loadUse), .mduBusy(mduBusy), .ifBusy(ifBusy), .ifRespValid(ifRespValid),
        .pcWriteEn(pcWriteEn), .pcSelect(pcSelect), .targetPc(targetPc),
        .stallIf(stallIf), .stallId(stallId), .stallEx(stallEx),
        .flushIfId(flushIfId), .flushIdEx(flushIdEx), .flushExMem(flushExMem),
        .mduKill(mduKill), .ifDiscard(ifDiscard)
    );

    // {we, sel, pc, stallIf, stallId, stallEx, flushIfId, flushIdEx, flushExMem, mduKill, ifDiscard}
    wire [42:0] obs = {pcWriteEn, pcSelect, targetPc, stallIf, stallId, stallEx,
                       flushIfId, flushIdEx, flushExMem, mduKill, ifDiscard};

    int checks = 0;
    int fails  = 0;

    // Model state: is a redirect parked, and which one
    logic        m_hold = 1'b0;
    logic [1:0]  m_sel  = 2'd0;
    logic [31:0] m_pc   = 32'd0;

    always @(posedge clk)
        if (arstn) assert (!(redirectValid && mduBusy))
            else $error("FAIL illegal_stim redirectValid with mduBusy");

    task automatic model_eval(output logic [42:0] o, output logic nh,
                              output logic [1:0] ns, output logic [31:0] np);
        logic we, si, sd, se, fi, fd, fe, mk, dis;
        logic [1:0] sel;
        logic [31:0] pc;
        {we, si, sd, se, fi, fd, fe, mk, dis} = '0;
        sel = 2'd0; pc = 32'd0;
        nh = m_hold; ns = m_sel; np = m_pc;
        if (!arstn) begin
            nh = 1'b0; ns = 2'd0; np = 32'd0;
        end else if (m_hold) begin
            sel = trapReq ? 2'd2 : m_sel;
            pc  = trapReq ? TV : m_pc;
            fi = 1'b1; fe = trapReq; mk = trapReq;
            we = ifRespValid; dis = ifRespValid;
            nh = !ifRespValid; ns = sel; np = pc;
        end else if (trapReq || mretReq || redirectValid) begin
            if (trapReq)      begin sel = 2'd2; pc = TV; end
            else if (mretReq) begin sel = 2'd3; pc = mepc; end
            else              begin sel = 2'd1; pc = redirectTarget; end
            fi = 1'b1; fd = 1'b1; fe = trapReq; mk = trapReq;
            we = !ifBusy;
            if (ifBusy) begin nh = 1'b1; ns = sel; np = pc; end
        end else if (mduBusy) begin
            si = 1'b1; sd = 1'b1; se = 1'b1;
        end else if (loadUse) begin
            si = 1'b1; sd = 1'b1; fd = 1'b1;
        end else begin
            we = !ifBusy;
        end
        o = {we, sel, pc, si, sd, se, fi, fd, fe, mk, dis};
    endtask

    // Advance one clock, moving the model with the inputs present at the edge
    task automatic tick();
        logic [42:0] o; logic nh; logic [1:0] ns; logic [31:0] np;
        model_eval(o, nh, ns, np);
        @(posedge clk);
        m_hold = nh; m_sel = ns; m_pc = np;
        #1;
    endtask

    task automatic idle();
        redirectValid = 0; trapReq = 0; mretReq = 0; loadUse = 0; mduBusy = 0;
        ifBusy = 0; ifRespValid = 0; redirectTarget = '0; mepc = 32'h0000_0a00;
    endtask

    task automatic test_reset();
        logic [42:0] e; logic nh; logic [1:0] ns; logic [31:0] np;
        idle();
        trapReq = 1; redirectValid = 1; ifRespValid = 1; loadUse = 1;
        @(negedge clk);
        if (obs !== 43'd0) begin fails++; $display("FAIL reset_outputs got=%h exp=0", obs); end
        checks++;
        tick();
        idle();
        #2 arstn = 1'b1;
        @(negedge clk); model_eval(e, nh, ns, np);
        if (obs !== e || pcWriteEn !== 1'b1 || pcSelect !== 2'd0) begin
            fails++; $display("FAIL reset_first_seq got=%h exp=%h", obs, e);
        end
        checks++;
        tick();
    endtask

    task automatic test_branch_idle();
        logic [42:0] e; logic nh; logic [1:0] ns; logic [31:0] np;
        idle(); redirectValid = 1; redirectTarget = 32'h0000_0040;
        @(negedge clk); model_eval(e, nh, ns, np);
        if (obs !== e || {pcWriteEn, pcSelect, targetPc, flushIfId, flushIdEx} !== {1'b1, 2'd1, 32'h40, 1'b1, 1'b1}) begin
            fails++; $display("FAIL branch_idle got=%h exp=%h", obs, e);
        end
        checks++;
        tick(); idle();
        @(negedge clk); model_eval(e, nh, ns, np);
        if (obs !== e || obs !== {1'b1, 42'd0}) begin
            fails++; $display("FAIL branch_idle_after got=%h exp=%h", obs, e);
        end
        checks++;
        tick();
    endtask

    task automatic test_branch_busy();
        logic [42:0] e; logic nh; logic [1:0] ns; logic [31:0] np;
        idle(); redirectValid = 1; redirectTarget = 32'h0000_0200; ifBusy = 1;
        @(negedge clk); model_eval(e, nh, ns, np);
        if (obs !== e || {pcWriteEn, flushIfId, flushIdEx} !== 3'b011) begin
            fails++; $display("FAIL branch_busy_enter got=%h exp=%h", obs, e);
        end
        checks++;
        tick();
        for (int c = 0; c < 3; c++) begin
            idle(); ifBusy = 1; ifRespValid = (c == 2);
            redirectValid = (c == 0); mretReq = (c == 1); redirectTarget = 32'h0000_0999 & ~32'h1;
            @(negedge clk); model_eval(e, nh, ns, np);
            if (obs !== e || flushIfId !== 1'b1 || pcWriteEn !== (c == 2) || ifDiscard !== (c == 2)
                || (c == 2 && (targetPc !== 32'h200 || pcSelect !== 2'd1))) begin
                fails++; $display("FAIL branch_busy_hold%0d got=%h exp=%h", c, obs, e);
            end
            checks++;
            tick();
        end
        idle(); ifRespValid = 1;
        @(negedge clk); model_eval(e, nh, ns, np);
        if (obs !== e || ifDiscard !== 1'b0 || pcWriteEn !== 1'b1) begin
            fails++; $display("FAIL branch_busy_exit got=%h exp=%h", obs, e);
        end
        checks++;
        tick();
    endtask

    task automatic test_priority();
        logic [42:0] e; logic nh; logic [1:0] ns; logic [31:0] np;
        idle(); trapReq = 1; mretReq = 1; redirectValid = 1; redirectTarget = 32'h44; loadUse = 1;
        @(negedge clk); model_eval(e, nh, ns, np);
        if (obs !== e || {pcSelect, targetPc, flushExMem, mduKill, pcWriteEn} !== {2'd2, 32'h100, 3'b111}) begin
            fails++; $display("FAIL priority_trap got=%h exp=%h", obs, e);
        end
        checks++;
        tick();
        idle(); mretReq = 1; redirectValid = 1; redirectTarget = 32'h44; mepc = 32'h0000_1234;
        @(negedge clk); model_eval(e, nh, ns, np);
        if (obs !== e || {pcSelect, targetPc, flushExMem, mduKill} !== {2'd3, 32'h1234, 2'b00}) begin
            fails++; $display("FAIL priority_mret got=%h exp=%h", obs, e);
        end
        checks++;
        tick();
    endtask

    task automatic test_trap_override();
        logic [42:0] e; logic nh; logic [1:0] ns; logic [31:0] np;
        idle(); redirectValid = 1; redirectTarget = 32'h80; ifBusy = 1;
        tick();
        idle(); trapReq = 1; ifBusy = 1;
        @(negedge clk); model_eval(e, nh, ns, np);
        if (obs !== e || {flushExMem, mduKill, pcWriteEn} !== 3'b110) begin
            fails++; $display("FAIL trap_in_hold got=%h exp=%h", obs, e);
        end
        checks++;
        tick();
        idle(); ifRespValid = 1;
        @(negedge clk); model_eval(e, nh, ns, np);
        if (obs !== e || {pcSelect, targetPc, ifDiscard, pcWriteEn} !== {2'd2, 32'h100, 2'b11}) begin
            fails++; $display("FAIL trap_override_exit got=%h exp=%h", obs, e);
        end
        checks++;
        tick();
    endtask

    task automatic test_stalls();
        logic [42:0] e; logic nh; logic [1:0] ns; logic [31:0] np;
        idle(); loadUse = 1;
        @(negedge clk); model_eval(e, nh, ns, np);
        if (obs !== e || {stallIf, stallId, stallEx, flushIdEx, pcWriteEn} !== 5'b11010) begin
            fails++; $display("FAIL load_use got=%h exp=%h", obs, e);
        end
        checks++;
        tick();
        for (int c = 0; c < 33; c++) begin
            idle(); mduBusy = 1; loadUse = c[0];
            @(negedge clk); model_eval(e, nh, ns, np);
            if (obs !== e || {stallIf, stallId, stallEx, flushIfId, flushIdEx, pcWriteEn} !== 6'b111000) begin
                fails++; $display("FAIL mdu_stall%0d got=%h exp=%h", c, obs, e);
            end
            checks++;
            tick();
        end
        idle();
        @(negedge clk); model_eval(e, nh, ns, np);
        if (obs !== e || pcWriteEn !== 1'b1) begin
            fails++; $display("FAIL mdu_release got=%h exp=%h", obs, e);
        end
        checks++;
        tick();
    endtask

    task automatic test_reset_hold();
        logic [42:0] e; logic nh; logic [1:0] ns; logic [31:0] np;
        idle(); redirectValid = 1; redirectTarget = 32'h300; ifBusy = 1;
        tick();
        idle(); trapReq = 1; ifBusy = 1; ifRespValid = 1;
        #2 arstn = 1'b0;
        #1;
        if (obs !== 43'd0) begin fails++; $display("FAIL reset_async got=%h exp=0", obs); end
        checks++;
        tick();
        idle(); ifRespValid = 1;
        #3 arstn = 1'b1;
        @(negedge clk); model_eval(e, nh, ns, np);
        if (obs !== e || pcWriteEn !== 1'b1 || ifDiscard !== 1'b0) begin
            fails++; $display("FAIL reset_hold_release got=%h exp=%h", obs, e);
        end
        checks++;
        tick();
    endtask

    task automatic test_random();
        logic [42:0] e; logic nh; logic [1:0] ns; logic [31:0] np;
        for (int c = 0; c < 400; c++) begin
            trapReq       = ($urandom_range(15) == 0);
            mretReq       = ($urandom_range(11) == 0);
            mduBusy       = ($urandom_range(5) == 0);
            redirectValid = !mduBusy && ($urandom_range(4) == 0);
            loadUse       = ($urandom_range(4) == 0);
            ifBusy        = $urandom_range(1);
            ifRespValid   = ($urandom_range(2) == 0);
            redirectTarget = $urandom() & ~32'h1;
            mepc          = $urandom() & ~32'h1;
            @(negedge clk); model_eval(e, nh, ns, np);
            if (obs !== e) begin fails++; $display("FAIL random%0d got=%h exp=%h", c, obs, e); end
            checks++;
            tick();
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_branch_idle();
        test_branch_busy();
        test_priority();
        test_trap_override();
        test_stalls();
        test_reset_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
